// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage feeding the 32-bit ALU: decodes RV32I OP-IMM/OP words,
// reads a write-back-updated register file and registers {op, in1, in2, rd} behind a valid/ready skid-free slot.
module alu_decode_stage #(
    parameter int WIDTH   = 32,
    parameter int OPWIDTH = 5,
    parameter int NREG    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPWIDTH-1:0] out_op,
    output logic [WIDTH-1:0]   out_in1,
    output logic [WIDTH-1:0]   out_in2,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    logic               out_valid_q, out_valid_d;
    logic [OPWIDTH-1:0] out_op_q, out_op_d;
    logic [WIDTH-1:0]   out_in1_q, out_in1_d;
    logic [WIDTH-1:0]   out_in2_q, out_in2_d;
    logic [4:0]         out_rd_q, out_rd_d;
    logic               out_illegal_q, out_illegal_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic signed [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] shamt;
    logic [WIDTH-1:0] rs1_val, rs2_val;
    logic [OPWIDTH-1:0] dec_op;
    logic [WIDTH-1:0]   dec_in2;
    logic               dec_ill;
    logic               accept;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_sext = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign shamt    = {{(WIDTH-5){1'b0}}, instr[24:20]};

    assign instr_ready = !out_valid_q || out_ready;
    assign accept      = instr_valid && instr_ready;

    // Register file reads, with a same-cycle write-back bypass; x0 is hardwired to zero.
    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        if (wb_en && wb_rd == rs1) rs1_val = wb_data;
        if (wb_en && wb_rd == rs2) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != 5'd0) regs_d[wb_rd] = wb_data;
    end

    always_comb begin
        dec_op  = '0;
        dec_in2 = rs2_val;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OPIMM: begin
                dec_in2 = imm_sext;
                case (funct3)
                    3'b000: dec_op = OPWIDTH'(0);
                    3'b010: dec_op = OPWIDTH'(1);
                    3'b011: dec_op = OPWIDTH'(2);
                    3'b100: dec_op = OPWIDTH'(3);
                    3'b110: dec_op = OPWIDTH'(4);
                    3'b111: dec_op = OPWIDTH'(5);
                    3'b001: begin
                        dec_in2 = shamt;
                        if (funct7 == F7_BASE) dec_op = OPWIDTH'(6);
                        else                   dec_ill = 1'b1;
                    end
                    3'b101: begin
                        dec_in2 = shamt;
                        if (funct7 == F7_BASE)     dec_op = OPWIDTH'(7);
                        else if (funct7 == F7_ALT) dec_op = OPWIDTH'(8);
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec_op = OPWIDTH'(9);
                        3'b001: dec_op = OPWIDTH'(11);
                        3'b010: dec_op = OPWIDTH'(12);
                        3'b011: dec_op = OPWIDTH'(13);
                        3'b100: dec_op = OPWIDTH'(14);
                        3'b101: dec_op = OPWIDTH'(15);
                        3'b110: dec_op = OPWIDTH'(17);
                        3'b111: dec_op = OPWIDTH'(18);
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  dec_op  = OPWIDTH'(10);
                        3'b101:  dec_op  = OPWIDTH'(16);
                        default: dec_ill = 1'b1;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Output slot: load on accept, drop valid once consumed, otherwise hold everything.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_in1_d     = out_in1_q;
        out_in2_d     = out_in2_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_illegal_d = dec_ill;
            if (dec_ill) begin
                out_op_d  = '0;
                out_in1_d = '0;
                out_in2_d = '0;
                out_rd_d  = '0;
            end else begin
                out_op_d  = dec_op;
                out_in1_d = rs1_val;
                out_in2_d = dec_in2;
                out_rd_d  = rd;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_in1_q     <= '0;
            out_in2_q     <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_in1_q     <= out_in1_d;
            out_in2_q     <= out_in2_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
            regs_q        <= regs_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_in1     = out_in1_q;
    assign out_in2     = out_in2_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: expected outputs are queued at accept and
// popped by a monitor on every output transfer.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    alu_decode_stage #(.WIDTH(32), .OPWIDTH(5), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_in1(out_in1), .out_in2(out_in2),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] op, input logic [31:0] in1,
                                input logic [31:0] in2, input logic [4:0] rd, input logic ill);
        exp_t e;
        e.op = op; e.in1 = in1; e.in2 = in2; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one pop per completed output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual op=%0d in1=%0h required=none", out_op, out_in1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("xfer%0d {op,in1,in2,rd,ill}", xfers),
                    80'({out_op, out_in1, out_in2, out_rd, out_illegal}), 80'(e));
            end
            xfers++;
        end
    end

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input exp_t e, output int waited);
        waited = 0;
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready instr=%h", w);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_out_valid", 80'(out_valid), 80'(0));
        chk("reset_outputs", 80'({out_op, out_in1, out_in2, out_rd, out_illegal}), 80'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_reset", 80'(instr_ready), 80'(1));

        // 1: write-back then ADD x3,x1,x2
        wb(5'd1, 32'd5);
        wb(5'd2, 32'hFFFF_FFFD);
        send(32'h0020_81B3, mk(5'd9, 32'd5, 32'hFFFF_FFFD, 5'd3, 1'b0), w);
        chk("add_latency_valid", 80'(out_valid), 80'(1));

        // 2: ADDI, SRAI and a few more decodes
        send(32'hFFF0_0213, mk(5'd0, 32'd0, 32'hFFFF_FFFF, 5'd4, 1'b0), w);
        send(32'h4030_D293, mk(5'd8, 32'd5, 32'd3, 5'd5, 1'b0), w);
        send(32'h0041_1513, mk(5'd6, 32'hFFFF_FFFD, 32'd4, 5'd10, 1'b0), w);
        send(32'h4011_55B3, mk(5'd16, 32'hFFFF_FFFD, 32'd5, 5'd11, 1'b0), w);
        send(32'h8000_B613, mk(5'd2, 32'd5, 32'hFFFF_F800, 5'd12, 1'b0), w);
        send(32'h4041_1513, mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b1), w);
        idle(2);

        // 3: backpressure with a second instruction waiting
        out_ready = 1'b0;
        send(32'h0070_0313, mk(5'd0, 32'd0, 32'd7, 5'd6, 1'b0), w);
        instr = 32'h0090_0393;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_instr_ready", i), 80'(instr_ready), 80'(0));
            chk($sformatf("stall%0d_held", i), 80'({out_valid, out_op, out_in2, out_rd}),
                80'({1'b1, 5'd0, 32'd7, 5'd6}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_instr_ready", 80'(instr_ready), 80'(1));
        exp_q.push_back(mk(5'd0, 32'd0, 32'd9, 5'd7, 1'b0));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        idle(2);
        chk("stall_no_loss_no_dup", 80'(xfers), 80'(9));

        // 4: same-cycle bypass, then x0 write ignored
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        send(32'h0010_81B3, mk(5'd9, 32'h1234, 32'h1234, 5'd3, 1'b0), w);
        wb_en = 1'b0;
        wb(5'd0, 32'hDEAD_BEEF);
        send(32'h0000_0433, mk(5'd9, 32'd0, 32'd0, 5'd8, 1'b0), w);
        send(32'h0000_84B3, mk(5'd9, 32'h1234, 32'd0, 5'd9, 1'b0), w);

        // 5: illegal words, accepted back-to-back
        send(32'h0000_007F, mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b1), w);
        chk("illegal1_accept_wait", 80'(w), 80'(0));
        send(32'h4020_91B3, mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b1), w);
        chk("illegal2_accept_wait", 80'(w), 80'(0));
        idle(2);

        // 6: asynchronous reset while holding an output
        out_ready = 1'b0;
        send(32'h0010_0693, mk(5'd0, 32'd0, 32'd1, 5'd13, 1'b0), w);
        chk("pre_reset_valid", 80'(out_valid), 80'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 80'(out_valid), 80'(0));
        chk("async_reset_outputs", 80'({out_op, out_in1, out_in2, out_rd}), 80'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h0000_8733, mk(5'd9, 32'd0, 32'd0, 5'd14, 1'b0), w);
        idle(3);

        chk("queue_drained", 80'(exp_q.size()), 80'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
